// File: rtl/prog_clk_div.sv
// ============================================================================
// Module   : prog_clk_div
// Brief    : Run-time programmable clock divider with near-50% duty, rise/fall
//            ticks, clean start/stop and period-aligned divisor updates.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_clk_div #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en_in,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load_in,
  output logic             div_busy_out,
  output logic             div_err_out,
  output logic [WIDTH-1:0] cur_div_out,
  output logic             clk_out,
  output logic             rise_tick_out,
  output logic             fall_tick_out
);

  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_TWO = WIDTH'(2);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [WIDTH-1:0] cur_div_q, cur_div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] half;
  logic             load_ok;
  logic             apply;

  // ceil(D/2) without a carry bit: floor(D/2) plus the LSB
  assign half    = (cur_div_q >> 1) + {{(WIDTH-1){1'b0}}, cur_div_q[0]};
  assign load_ok = div_load_in && (div_in >= C_TWO);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clk_d     = clk_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    cur_div_d = cur_div_q;
    pend_d    = pend_q;
    busy_d    = busy_q;
    err_d     = div_load_in && !load_ok;
    apply     = 1'b0;

    case (state_q)
      IDLE: begin
        clk_d = 1'b0;
        cnt_d = '0;
        if (en_in) begin
          state_d = RUN;
          clk_d   = 1'b1;
          rise_d  = 1'b1;
          apply   = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == cur_div_q - C_ONE) begin
          cnt_d = '0;
          if (en_in) begin
            clk_d  = 1'b1;
            rise_d = 1'b1;
            apply  = 1'b1;
          end else begin
            state_d = IDLE;
            clk_d   = 1'b0;
          end
        end else if (cnt_q == half - C_ONE) begin
          cnt_d  = cnt_q + C_ONE;
          clk_d  = 1'b0;
          fall_d = 1'b1;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        clk_d   = 1'b0;
      end
    endcase

    // Old pending value is consumed first so a same-edge load becomes the new pending
    if (apply && busy_q) begin
      cur_div_d = pend_q;
      busy_d    = 1'b0;
    end

    if (load_ok) begin
      if ((state_q == IDLE) && !en_in) begin
        cur_div_d = div_in;
        busy_d    = 1'b0;
      end else begin
        pend_d = div_in;
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      clk_q     <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      cur_div_q <= WIDTH'(DEFAULT_DIV);
      pend_q    <= WIDTH'(DEFAULT_DIV);
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clk_q     <= clk_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      cur_div_q <= cur_div_d;
      pend_q    <= pend_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign clk_out       = clk_q;
  assign rise_tick_out = rise_q;
  assign fall_tick_out = fall_q;
  assign cur_div_out   = cur_div_q;
  assign div_busy_out  = busy_q;
  assign div_err_out   = err_q;

endmodule

`default_nettype wire

// File: doc/prog_clk_div.md
Name: prog_clk_div

Overview:
- Parametrised, run-time programmable clock divider. It generates a divided clock enable/waveform `clk_out` from `clk_in`.
- Supports any integer divide ratio 2..2^WIDTH-1, with near-50% duty for both odd and even ratios.
- Divisor changes are glitch-free and take effect on a period boundary.
- Start and stop are clean, and rise/fall tick pulses drive downstream synchronous logic.

Parameters:
- WIDTH, 8, bit width of divisor and phase counter.
- DEFAULT_DIV, 2, divisor active after reset; must satisfy 2 <= DEFAULT_DIV <= 2^WIDTH-1.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous reset, active-high.
- en_in  input  1  run request; level-sensitive.
- div_in  input  WIDTH  new divisor value.
- div_load_in  input  1  one-cycle strobe; samples div_in.
- div_busy_out  output  1  high while an accepted divisor is pending application.
- div_err_out  output  1  one-cycle pulse when a load with div_in < 2 is rejected.
- cur_div_out  output  WIDTH  divisor currently in effect.
- clk_out  output  1  divided clock, registered.
- rise_tick_out  output  1  high exactly in the first cycle clk_out is 1 each period.
- fall_tick_out  output  1  high exactly in the first cycle clk_out is 0 after a high phase.

Behaviour:
- Reset (rst_in=1 sampled at a clk_in edge) sets the following, overriding all other inputs:
  - state=IDLE, cnt=0, clk_out=0, both ticks=0;
  - cur_div_out=DEFAULT_DIV, pending cleared, div_busy_out=0, div_err_out=0.
- Terms: D = cur_div_out; H = (D+1)>>1, so the high phase is H cycles and the low phase is D-H cycles.
  - D=2 gives 1/1; D=3 gives 2/1; D=7 gives 4/3.
- IDLE: clk_out=0, cnt=0.
  - If en_in=1, the next edge enters RUN with clk_out=1, rise_tick_out=1, cnt=0.
  - A pending divisor is applied on this same edge.
- RUN, evaluated per cycle in this priority:
  - cnt==D-1 (end of low phase):
    - en_in=1: cnt<=0, clk_out<=1, rise_tick<=1, pending divisor applied.
    - en_in=0: go IDLE, clk_out stays 0.
  - cnt==H-1: cnt<=cnt+1, clk_out<=0, fall_tick<=1.
  - otherwise: cnt<=cnt+1.
- Stop is clean: deasserting en_in never truncates a phase. The block always finishes the current full period, ending low, before entering IDLE.
- The first rising edge of clk_out appears 1 cycle after en_in is sampled high in IDLE.
- Divisor load:
  - div_load_in=1 with div_in>=2 stores div_in in the pending register; div_busy_out=1 from the next cycle.
  - div_load_in=1 with div_in<2: ignored, div_err_out=1 next cycle, pending unchanged.
  - In IDLE with en_in=0, an accepted load is applied directly: cur_div_out updates next cycle and div_busy_out stays 0.
  - In RUN, pending is applied only at a period boundary (the rise edge), then div_busy_out clears.
  - A load while busy overwrites pending; last write wins.
  - A load in the same cycle as an application edge: the old pending is applied and the new value becomes pending (busy stays 1).
- The counter never exceeds D-1. Because D changes only at cnt reset, no out-of-range compare is possible.
- Ticks are single-cycle, registered, and aligned with the clk_out transition they mark.
  - rise_tick and fall_tick are never high together.
- Reset mid-period or mid-load: all state returns to reset values on that edge and any pending divisor is discarded.

Test Plan:
- Reset, then en_in=1 with DEFAULT_DIV=2: clk_out toggles 1,0,1,0 every cycle; rise_tick on each 1-cycle; cur_div_out=2.
- Load div_in=7 in IDLE, then enable: clk_out is high 4 cycles and low 3, period 7; fall_tick at cycle 4 of each period.
- Running at D=4, load div_in=5 mid-high-phase:
  - div_busy_out=1 until the next rise;
  - the current period completes at 4;
  - the next period is 5 with high 3, low 2;
  - cur_div_out changes on the rise cycle.
- Load div_in=1 and then div_in=0: div_err_out pulses once for each; cur_div_out and busy are unchanged.
- Drop en_in during the high phase with D=6: clk_out finishes 3 high + 3 low, then stays 0 in IDLE; no extra rise_tick.
- Assert rst_in during RUN with a pending load of 9:
  - next cycle clk_out=0, busy=0, cur_div_out=DEFAULT_DIV;
  - re-enabling uses DEFAULT_DIV, not 9.
